// File: rtl/issue_queue.sv
// issue_queue -- circular-buffer issue queue between decode and issue.
//
// Accepts up to two entries per cycle from decode (lane 0 older) and presents
// the two oldest entries to issue. Issue reports how many it consumed; that
// count is clamped to the current occupancy. A pushed entry becomes visible
// on issue_require in the cycle after the push (no same-cycle bypass).
//
// Optional feature macro: IQ_FLUSH_EN -- adds the 'flush' input, which
// empties the queue at the next edge (rst still takes priority).
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   push_num       entries offered this cycle (0..2, 3 treated as 2)
//   push_data      offered entries, lane 0 older
//   push_ready     room for two entries this cycle (from registered state)
//   issue_require  head (lane 0) and head+1 (lane 1); zero when lane invalid
//   iq_head_valid  per-lane validity of issue_require
//   iq_size        current occupancy, 0..IQ_DEPTH
//   iq_pop_number  entries consumed by issue this cycle (0..2, 3 treated as 2)
//   flush          (IQ_FLUSH_EN only) discard all entries
module issue_queue #(
  parameter int IQ_DEPTH = 16,
  parameter int ELEM_W   = 32,
  localparam int PTR_W   = $clog2(IQ_DEPTH),
  localparam int IQ_ADDR = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             push_num,
  input  logic [1:0][ELEM_W-1:0] push_data,
  output logic                   push_ready,
  output logic [1:0][ELEM_W-1:0] issue_require,
  output logic [1:0]             iq_head_valid,
  output logic [IQ_ADDR-1:0]     iq_size,
  input  logic [1:0]             iq_pop_number
`ifdef IQ_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [IQ_ADDR-1:0] count;

  // Storage is intentionally not reset; only pointers/count define validity.
  logic [ELEM_W-1:0]  mem [IQ_DEPTH];

  logic [1:0]         push_req;
  logic [1:0]         push_cnt;
  logic [1:0]         pop_req;
  logic [1:0]         pop_cnt;
  logic [PTR_W-1:0]   head_p1;
  logic [PTR_W-1:0]   tail_p1;
  logic               clear;

`ifdef IQ_FLUSH_EN
  assign clear = rst | flush;
`else
  assign clear = rst;
`endif

  always_comb begin
    push_ready = (IQ_ADDR'(IQ_DEPTH) - count) >= IQ_ADDR'(2);

    push_req = (push_num == 2'd3) ? 2'd2 : push_num;
    push_cnt = push_ready ? push_req : '0;

    // Pop is clamped to what is actually held; count < 2 fits in two bits.
    pop_req = (iq_pop_number == 2'd3) ? 2'd2 : iq_pop_number;
    pop_cnt = (IQ_ADDR'(pop_req) > count) ? count[1:0] : pop_req;

    head_p1 = head + PTR_W'(1);
    tail_p1 = tail + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      mem[tail] <= push_data[0];
    end
    if (push_cnt == 2'd2) begin
      mem[tail_p1] <= push_data[1];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count + IQ_ADDR'(push_cnt) - IQ_ADDR'(pop_cnt);
    end
  end

  always_comb begin
    iq_size          = count;
    iq_head_valid[0] = (count >= IQ_ADDR'(1));
    iq_head_valid[1] = (count >= IQ_ADDR'(2));
    issue_require[0] = iq_head_valid[0] ? mem[head]    : '0;
    issue_require[1] = iq_head_valid[1] ? mem[head_p1] : '0;
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a driver issues stimulus and records
// the expected queue contents; a monitor applies each cycle's pop/clear event
// and compares every DUT output against that reference queue.
module tb_issue_queue;

  localparam int DEPTH = 16;
  localparam int W     = 32;
  localparam int AW    = $clog2(DEPTH) + 1;
`ifdef IQ_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        push_num = '0;
  logic [1:0][W-1:0] push_data = '0;
  logic              push_ready;
  logic [1:0][W-1:0] issue_require;
  logic [1:0]        iq_head_valid;
  logic [AW-1:0]     iq_size;
  logic [1:0]        iq_pop_number = '0;
`ifdef IQ_FLUSH_EN
  logic              flush = 1'b0;
`endif

  issue_queue #(.IQ_DEPTH(DEPTH), .ELEM_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_num      (push_num),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .issue_require (issue_require),
    .iq_head_valid (iq_head_valid),
    .iq_size       (iq_size),
    .iq_pop_number (iq_pop_number)
`ifdef IQ_FLUSH_EN
    ,
    .flush         (flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit clear;
    int npop;
  } ev_t;

  logic [W-1:0] sb[$];   // reference queue contents, oldest first
  ev_t          evq[$];  // one event per clock edge
  int           mcount = 0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record its expected effect.
  task automatic drive(input bit r, input bit f, input int pn, input int pp);
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int np;
    int npop;
    bit clr;
    ev_t ev;
    @(negedge clk);
    d0 = $urandom() | 32'h1;
    d1 = $urandom() | 32'h1;
    rst           = r;
    push_num      = pn[1:0];
    push_data[0]  = d0;
    push_data[1]  = d1;
    iq_pop_number = pp[1:0];
`ifdef IQ_FLUSH_EN
    flush = f;
`endif
    clr = r || (f && FLUSH_EN);
    if (clr) begin
      mcount   = 0;
      ev.clear = 1'b1;
      ev.npop  = 0;
    end else begin
      np = (DEPTH - mcount >= 2) ? ((pn > 2) ? 2 : pn) : 0;
      if (np >= 1) sb.push_back(d0);
      if (np == 2) sb.push_back(d1);
      npop = (pp > 2) ? 2 : pp;
      if (npop > mcount) npop = mcount;
      mcount   = mcount + np - npop;
      ev.clear = 1'b0;
      ev.npop  = npop;
    end
    evq.push_back(ev);
  endtask

  // Monitor: after each edge, retire the edge's event, then compare outputs.
  initial begin
    ev_t ev;
    int  sz;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    forever begin
      @(posedge clk);
      #1;
      if (evq.size() != 0) begin
        ev = evq.pop_front();
        if (ev.clear) sb.delete();
        else for (int i = 0; i < ev.npop; i++) void'(sb.pop_front());
        sz = sb.size();
        e0 = (sz >= 1) ? sb[0] : '0;
        e1 = (sz >= 2) ? sb[1] : '0;
        chk("iq_size", 64'(iq_size), 64'(sz));
        chk("push_ready", 64'(push_ready), 64'((DEPTH - sz) >= 2));
        chk("head_valid0", 64'(iq_head_valid[0]), 64'(sz >= 1));
        chk("head_valid1", 64'(iq_head_valid[1]), 64'(sz >= 2));
        chk("lane0", 64'(issue_require[0]), 64'(e0));
        chk("lane1", 64'(issue_require[1]), 64'(e1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int pp;
    // Reset, then two entries in one cycle.
    drive(1, 0, 0, 0);
    drive(1, 0, 2, 2);
    drive(0, 0, 2, 0);
    drive(0, 0, 0, 0);

    // Fill to 15 with single pushes; further pushes are dropped.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 3, 0);
    drive(0, 0, 0, 0);

    // Size 3, simultaneous push 2 / pop 2, then over-pop clamping.
    drive(1, 0, 0, 0);
    drive(0, 0, 2, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 2, 2);
    drive(0, 0, 0, 2);
    drive(0, 0, 0, 2);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 2);
    drive(0, 0, 0, 3);

    // Reset mid-operation with push and pop requested.
    drive(0, 0, 2, 0);
    drive(0, 0, 2, 1);
    drive(1, 0, 2, 2);
    drive(0, 0, 0, 0);

    // 40-entry stream, head wraps past index 15.
    for (int i = 0; i < 40; i++) drive(0, 0, 1, (i >= 4) ? 1 : 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1);

    // Flush with a same-cycle push (only meaningful when the feature exists).
    if (FLUSH_EN) begin
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 2, 0);
      drive(0, 0, 1, 0);
      drive(0, 1, 2, 0);
      drive(0, 0, 0, 0);
    end

    // Randomised traffic, alternating fill-biased and balanced phases.
    for (int i = 0; i < 600; i++) begin
      pp = ((i % 200) < 100) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
            $urandom_range(0, 3), pp);
    end

    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 16, meaning the number of entries; power of two, at least 4.
REQ-002 SHALL type IQ_ADDR as log2(IQ_DEPTH)+1 bits, so it can hold an occupancy of 0..IQ_DEPTH.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 push_num  input  2  entries offered by decode this cycle (0..2).
REQ-006 push_data  input  ISSUE_QUEUE_ELEMENT[1:0]  offered entries; lane 0 is older.
REQ-007 push_ready  output  1  queue can accept two entries this cycle.
REQ-008 issue_require  output  ISSUE_QUEUE_ELEMENT[1:0]  head entry (lane 0) and head+1 entry (lane 1), sent to issue.
REQ-009 iq_head_valid  output  2  per-lane validity of issue_require.
REQ-010 iq_size  output  IQ_ADDR  current occupancy.
REQ-011 iq_pop_number  input  2  entries consumed by issue this cycle (0..2).
REQ-012 flush  input  1  discard all entries; present only under IQ_FLUSH_EN.

Function
REQ-013 SHALL be a circular buffer with head pointer, tail pointer and count, each log2(IQ_DEPTH) bits wide (count is IQ_ADDR wide); pointers wrap modulo IQ_DEPTH.
REQ-014 SHALL drive push_ready = 1 when (IQ_DEPTH - iq_size) >= 2, computed only from registered state.
REQ-015 SHALL accept a push only when push_ready = 1; when push_ready = 0, push_num is ignored.
REQ-016 On an accepted push, SHALL write lane 0 at tail and lane 1 at tail+1 (lane 1 only when push_num = 2), then advance tail by push_num; push_num = 3 SHALL be treated as 2.
REQ-017 SHALL clamp the effective pop count to min(iq_pop_number, iq_size), treating 3 as 2; head advances by the effective pop count.
REQ-018 SHALL apply a simultaneous push and pop in the same cycle: next iq_size = iq_size + pushed - popped.
REQ-019 SHALL give a pushed entry 1-cycle latency: it is visible on issue_require no earlier than the cycle after the push. There is no same-cycle bypass.
REQ-020 SHALL drive iq_head_valid[0] = (iq_size >= 1) and iq_head_valid[1] = (iq_size >= 2).
REQ-021 SHALL drive issue_require lanes from storage at head and head+1 (modulo IQ_DEPTH); each lane SHALL be all-zero when its iq_head_valid bit is 0.
REQ-022 SHALL preserve strict FIFO order across wrap-around; lane 1 reads index 0 when head = IQ_DEPTH-1.
REQ-023 Storage entries SHALL NOT be reset; correctness relies only on the pointers and count.

Reset
REQ-024 While rst = 1 at a clock edge, head, tail and count SHALL become 0, and push and pop that cycle SHALL be ignored.
REQ-025 After reset, outputs SHALL be iq_size = 0, iq_head_valid = 00, issue_require = all-zero and push_ready = 1.
REQ-026 Reset asserted mid-operation SHALL discard all entries, with the same result as REQ-024.

Configuration
REQ-027 Macro IQ_FLUSH_EN SHALL control the flush feature.
- Defined: flush port exists; flush = 1 sets head = tail = count = 0 at the next edge, with priority over push and pop that cycle; rst has priority over flush.
- Undefined: no flush port and no flush logic; behaviour is otherwise identical.

Verification
REQ-028 Reset, then push_num=2 with entries A,B -> next cycle iq_size=2, issue_require={A,B}, iq_head_valid=11.
REQ-029 Push 15 single entries into an empty queue (IQ_DEPTH=16), no pops -> iq_size=15, push_ready=0; a further push_num=1 is dropped and iq_size stays 15.
REQ-030 iq_size=1 with entry A, iq_pop_number=2 -> pop clamped to 1; next cycle iq_size=0, iq_head_valid=00, issue_require all-zero.
REQ-031 iq_size=3, push_num=2 and iq_pop_number=2 in the same cycle -> next iq_size=3; the head is the old third entry, followed by the first new entry.
REQ-032 Fill and drain 40 entries in a continuous stream with head crossing index 15 -> output order matches push order exactly; no loss or duplication.
REQ-033 With IQ_FLUSH_EN: iq_size=9, flush=1 with push_num=2 in the same cycle -> next iq_size=0 and push_ready=1; the pushed entries are discarded.
